// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests, and
// queues returned {pc, instr} pairs for IF/ID. Optional FETCH_BYPASS_EN forwards
// a response straight to the outputs when the queue is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_stall
);

  localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW  = AW + 1;  // 0..DEPTH
  localparam int          DW  = AW + 2;  // 0..2*DEPTH
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [AW-1:0] q_head, q_tail;
  logic [CW-1:0] count;
  logic [31:0]   ifl_pc  [DEPTH];
  logic [AW-1:0] ifl_head, ifl_tail;
  logic [CW-1:0] live;   // outstanding requests whose responses will be kept
  logic [DW-1:0] drop;   // outstanding requests whose responses will be discarded

  logic          resp_live, byp, take, q_push, q_pop, acc;
  logic [DW-1:0] reserved, outst;

  always_comb begin
    resp_live = imem_resp_valid && (drop == '0);
`ifdef FETCH_BYPASS_EN
    byp       = (count == '0) && resp_live;
`else
    byp       = 1'b0;
`endif
    if_valid  = (count != '0) || byp;
    if_pc     = 32'h0;
    if_instr  = NOP;
    if (count != '0) begin
      if_pc    = q_pc[q_head];
      if_instr = q_instr[q_head];
    end
`ifdef FETCH_BYPASS_EN
    else if (byp) begin
      if_pc    = ifl_pc[ifl_head];
      if_instr = imem_resp_data;
    end
`endif
    fetch_stall = !if_valid;
    take        = if_valid && !stall;
    q_pop       = take && (count != '0);
    // A bypassed response consumed this cycle never occupies a queue slot.
    q_push      = resp_live && !redirect_valid && !(byp && !stall);

    // Credit counts queued plus kept-in-flight entries, crediting a slot that
    // frees this cycle so k=1 sustains one fetch per cycle. The outstanding cap
    // bounds the drop counter across back-to-back redirects.
    reserved       = DW'(count) + DW'(live);
    outst          = DW'(live) + drop;
    imem_req_valid = !reset && !redirect_valid &&
                     (reserved < DW'(DEPTH) + DW'(take)) &&
                     (outst < DW'(2 * DEPTH));
    imem_req_addr  = fetch_pc;
    acc            = imem_req_valid && imem_req_ready;
  end

  // Storage arrays carry no reset; pointers and counts qualify their contents.
  always_ff @(posedge clk) begin
    if (acc)    ifl_pc[ifl_tail] <= fetch_pc;
    if (q_push) begin
      q_pc[q_tail]    <= ifl_pc[ifl_head];
      q_instr[q_tail] <= imem_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      q_head   <= '0;
      q_tail   <= '0;
      count    <= '0;
      ifl_head <= '0;
      ifl_tail <= '0;
      live     <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Every response still owed by memory is now stale, including kept ones.
      fetch_pc <= redirect_pc;
      q_head   <= '0;
      q_tail   <= '0;
      count    <= '0;
      ifl_head <= '0;
      ifl_tail <= '0;
      live     <= '0;
      drop     <= drop + DW'(live) - DW'(imem_resp_valid);
    end else begin
      if (acc) begin
        fetch_pc <= fetch_pc + 32'd4;
        ifl_tail <= ifl_tail + AW'(1);
      end
      if (resp_live) ifl_head <= ifl_head + AW'(1);
      if (q_push)    q_tail   <= q_tail + AW'(1);
      if (q_pop)     q_head   <= q_head + AW'(1);
      if (imem_resp_valid && (drop != '0)) drop <= drop - DW'(1);
      count <= count + CW'(q_push) - CW'(q_pop);
      live  <= live + CW'(acc) - CW'(resp_live);
    end
  end

endmodule
